// File: rtl/ifetch_queue_pkg.sv
// Shared types and exception codes for the instruction fetch queue.
// Slot layout is common to the ring storage and the fetch front end.
package ifetch_queue_pkg;

    localparam logic [7:0] ECODE_ADEF    = 8'h08;
    localparam logic       ESUBCODE_ADEF = 1'b0;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_slot_t;

    function automatic ifq_slot_t new_slot(input logic [31:0] pc);
        ifq_slot_t s;
        s       = '0;
        s.valid = 1'b1;
        s.pc    = pc;
        // A misaligned pc never reaches the bus; it becomes a ready ADEF entry.
        if (pc[1:0] != 2'b00) begin
            s.done     = 1'b1;
            s.ex       = 1'b1;
            s.ecode    = ECODE_ADEF;
            s.esubcode = ESUBCODE_ADEF;
        end
        return s;
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction bus and fetch-to-decode bundle of the fetch queue.
// master is the fetch unit side, slave is memory plus decode.
interface ifetch_queue_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_inst;
    logic        fd_ex;
    logic [7:0]  fd_ecode;
    logic        fd_esubcode;
    logic        d_allowin;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output fd_valid, fd_pc, fd_inst,
        output fd_ex, fd_ecode, fd_esubcode,
        input  d_allowin
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  fd_valid, fd_pc, fd_inst,
        input  fd_ex, fd_ecode, fd_esubcode,
        output d_allowin
    );

endinterface

// File: rtl/ifq_ring.sv
// Circular slot store: allocate at tail, fill in order, pop at head.
// pend counts allocated slots still waiting for read data.
module ifq_ring
    import ifetch_queue_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          alloc,
    input  ifq_slot_t     alloc_slot,
    input  logic          fill,
    input  logic [31:0]   fill_inst,
    input  logic          pop,
    output ifq_slot_t     head_slot,
    output logic [CW-1:0] count,
    output logic [CW-1:0] pend
);

    ifq_slot_t     slots [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            fptr  <= '0;
            count <= '0;
            pend  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            head  <= tail;
            fptr  <= tail;
            count <= '0;
            pend  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                slots[i].valid <= 1'b0;
                slots[i].done  <= 1'b0;
                slots[i].ex    <= 1'b0;
            end
        end else begin
            if (alloc) begin
                slots[tail] <= alloc_slot;
                tail        <= tail + PW'(1);
            end
            // fptr may rest on a ready ADEF slot; pend is zero then.
            if (fill) begin
                slots[fptr].inst <= fill_inst;
                slots[fptr].done <= 1'b1;
                fptr             <= fptr + PW'(1);
            end
            if (pop) begin
                slots[head].valid <= 1'b0;
                head              <= head + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
            pend  <= pend + CW'(alloc && !alloc_slot.done)
                          - CW'(fill);
        end
    end

    assign head_slot = slots[head];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC, redirect handling and bus issue in front of the slot ring.
// Responses to flushed requests are swallowed via the discard count.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_en,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    ifetch_queue_if.master ifq
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   pc_q;
    logic [CW-1:0] discard;
    logic          adef_hold;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          aligned;
    logic          can_go;
    logic [CW:0]   in_use;
    logic          issue;
    logic          adef_alloc;
    logic          alloc;
    logic          fill;
    logic          drop;
    logic          pop;
    ifq_slot_t     alloc_slot;
    ifq_slot_t     head_slot;
    logic [CW-1:0] count;
    logic [CW-1:0] pend;

    always_comb begin
        redirect    = ex_en | ertn_flush | br_taken;
        redirect_pc = br_target;
        priority case (1'b1)
            ex_en:      redirect_pc = ex_entry;
            ertn_flush: redirect_pc = ertn_pc;
            default:    redirect_pc = br_target;
        endcase
    end

    assign aligned    = pc_q[1:0] == 2'b00;
    assign can_go     = rstn && !redirect && !adef_hold;
    // Discarded requests are still on the bus, so they hold slots too.
    assign in_use     = (CW+1)'(count) + (CW+1)'(discard);

    assign ifq.inst_req  = can_go && aligned
                        && in_use < (CW+1)'(QDEPTH);
    assign ifq.inst_addr = pc_q;

    assign issue      = ifq.inst_req && ifq.inst_addr_ok;
    assign adef_alloc = can_go && !aligned
                     && count < CW'(QDEPTH);
    assign alloc      = issue || adef_alloc;
    assign alloc_slot = new_slot(pc_q);

    assign fill = ifq.inst_data_ok && discard == '0
               && pend != '0;
    assign drop = ifq.inst_data_ok && discard != '0;

    assign ifq.fd_valid    = rstn && !redirect && count != '0
                          && head_slot.valid && head_slot.done;
    assign ifq.fd_pc       = head_slot.pc;
    assign ifq.fd_inst     = head_slot.inst;
    assign ifq.fd_ex       = head_slot.ex;
    assign ifq.fd_ecode    = head_slot.ecode;
    assign ifq.fd_esubcode = head_slot.esubcode;

    assign pop = ifq.fd_valid && ifq.d_allowin;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q      <= RESET_PC;
            discard   <= '0;
            adef_hold <= 1'b0;
        end else if (redirect) begin
            pc_q      <= redirect_pc;
            discard   <= discard + pend
                       - CW'(fill) - CW'(drop);
            adef_hold <= 1'b0;
        end else begin
            if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            if (adef_alloc) begin
                adef_hold <= 1'b1;
            end
            if (drop) begin
                discard <= discard - CW'(1);
            end
        end
    end

    ifq_ring #(
        .QDEPTH(QDEPTH)
    ) u_ring (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect),
        .alloc     (alloc),
        .alloc_slot(alloc_slot),
        .fill      (fill),
        .fill_inst (ifq.inst_rdata),
        .pop       (pop),
        .head_slot (head_slot),
        .count     (count),
        .pend      (pend)
    );

endmodule
